// File: rtl/peek_cmd_exec.sv
// peek_cmd_exec: executes memory peek/poke commands posted by an SPI peek slave.
// A command is picked up when its tag differs from the last accepted tag; the
// result is reported through the status word once the command has finished.
module peek_cmd_exec #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [63:0] cmd,
  output logic [63:0] status,
  output logic        mem_req,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  // Timer counts ISSUE cycles 0 .. ACK_TIMEOUT-1; the last value is the expiry cycle.
  localparam int unsigned  TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    NEXT,
    DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_WRITE = 4'd1,
    OP_READ  = 4'd2,
    OP_FILL  = 4'd3,
    OP_CHECK = 4'd4
  } op_e;

  state_e state_q, state_d;

  // Command word fields
  logic [7:0]  cmd_tag;
  logic [3:0]  cmd_op;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [15:0] cmd_data;

  assign cmd_tag  = cmd[63:56];
  assign cmd_op   = cmd[55:52];
  assign cmd_addr = cmd[51:32];
  assign cmd_len  = cmd[31:16];
  assign cmd_data = cmd[15:0];

  // Latched command context
  logic [7:0]    last_tag;
  logic [3:0]    op_q;
  logic [15:0]   data_q;
  logic [15:0]   remaining;
  logic [TW-1:0] timer;

  // Status fields
  logic [7:0]  done_tag;
  logic [3:0]  done_op;
  logic        busy;
  logic        bad_op;
  logic        timed_out;
  logic [15:0] mism_cnt;
  logic [15:0] last_rd;
  logic [15:0] words;

  logic accept;
  logic need_access;
  logic timer_exp;

  // Bit 48 is a reserved field that always reads as zero.
  assign status = {done_tag, done_op, busy, bad_op, timed_out, 1'b0, mism_cnt, last_rd, words};

  // Request is a pure decode of the state register so reset drops it immediately.
  assign mem_req   = (state_q == ISSUE);
  assign timer_exp = (timer == TIMER_LAST);

  // Decide whether the presented command touches memory at all.
  always_comb begin
    need_access = 1'b0;
    if ((cmd_op == OP_WRITE) || (cmd_op == OP_READ)) begin
      need_access = 1'b1;
    end else if ((cmd_op == OP_FILL) || (cmd_op == OP_CHECK)) begin
      need_access = (cmd_len != '0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and command acceptance strobe.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_tag != last_tag) begin
          accept  = 1'b1;
          state_d = need_access ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        // An ack landing on the expiry cycle wins over the timeout.
        if (mem_ack) begin
          state_d = NEXT;
        end else if (timer_exp) begin
          state_d = DONE;
        end
      end
      NEXT: begin
        state_d = (remaining > 16'd1) ? ISSUE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: command latch, address/count stepping, ack timer and status fields.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      last_tag  <= '0;
      op_q      <= '0;
      data_q    <= '0;
      remaining <= '0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done_tag  <= '0;
      done_op   <= '0;
      busy      <= 1'b0;
      bad_op    <= 1'b0;
      timed_out <= 1'b0;
      mism_cnt  <= '0;
      last_rd   <= '0;
      words     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_tag  <= cmd_tag;
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            remaining <= ((cmd_op == OP_FILL) || (cmd_op == OP_CHECK)) ? cmd_len : 16'd1;
            timer     <= '0;
            mem_we    <= (cmd_op == OP_WRITE) || (cmd_op == OP_FILL);
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_data;
            busy      <= 1'b1;
            bad_op    <= (cmd_op > OP_CHECK);
            timed_out <= 1'b0;
            mism_cnt  <= '0;
            last_rd   <= '0;
            words     <= '0;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            words <= words + 16'd1;
            if (!mem_we) begin
              last_rd <= mem_rdata;
            end
            if ((op_q == OP_CHECK) && (mem_rdata != data_q) && (mism_cnt != '1)) begin
              mism_cnt <= mism_cnt + 16'd1;
            end
          end else if (timer_exp) begin
            timed_out <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        NEXT: begin
          mem_addr  <= mem_addr + 20'd1;
          remaining <= remaining - 16'd1;
          timer     <= '0;
        end
        DONE: begin
          done_tag <= last_tag;
          done_op  <= op_q;
          busy     <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peek_cmd_exec.sv
// tb_peek_cmd_exec: scoreboard bench for peek_cmd_exec with a delayed-ack memory
// responder and a word-level reference model of each command.
module tb_peek_cmd_exec;

  localparam int unsigned TO       = 15;
  localparam int unsigned WAIT_MAX = 2000;

  logic        clk    = 1'b0;
  logic        reset_ = 1'b0;
  logic [63:0] cmd    = '0;
  logic [63:0] status;
  logic        mem_req;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [63:0] exp_status[$];

  bit [15:0] ref_mem [0:1048575];
  bit        ref_wr  [0:1048575];
  bit [15:0] sim_mem [0:1048575];
  bit        sim_wr  [0:1048575];
  logic [7:0] ref_last_tag = 8'h00;

  bit          ack_en    = 1'b1;
  int unsigned ack_delay = 0;
  int unsigned wcnt      = 0;
  bit          spur_en   = 1'b1;

  always #5 clk = ~clk;

  peek_cmd_exec #(.ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .cmd       (cmd),
    .status    (status),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Contents of never-written memory words.
  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {12'h000, a[19:16]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: acks ack_delay cycles after first seeing a request,
  // plus an occasional stray ack while the block is idle.
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      wcnt      <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end else if (mem_req) begin
      if (ack_en) begin
        if (wcnt >= ack_delay) begin
          mem_ack <= 1'b1;
          if (mem_we) begin
            sim_mem[mem_addr] <= mem_wdata;
            sim_wr[mem_addr]  <= 1'b1;
          end else begin
            mem_rdata <= sim_wr[mem_addr] ? sim_mem[mem_addr] : init_val(mem_addr);
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end else begin
      wcnt <= 0;
      if (spur_en && !status[51] && (cmd[63:56] == status[63:56]) && ($urandom_range(0, 3) == 0)) begin
        mem_ack   <= 1'b1;
        mem_rdata <= 16'($urandom);
      end
    end
  end

  // Scoreboard monitor: checks each acked access, request protocol, and each completion.
  bit   prev_req  = 1'b0;
  bit   prev_ack  = 1'b0;
  bit   prev_busy = 1'b0;
  acc_t prev_acc  = '0;

  always @(negedge clk) begin
    acc_t        e;
    logic [63:0] es;
    if (!reset_) begin
      prev_req  <= 1'b0;
      prev_ack  <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL acc_unexpected actual we=%b addr=%h required=none", mem_we, mem_addr);
        end else begin
          e = exp_acc.pop_front();
          check("acc_we", 64'(mem_we), 64'(e.we));
          check("acc_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("acc_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
      if (prev_ack) check("req_drop_after_ack", 64'(mem_req), 64'd0);
      if (prev_req && !prev_ack && mem_req)
        check("req_hold_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(prev_acc));
      if (prev_busy && !status[51]) begin
        if (exp_status.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL status_unexpected actual=%h required=none", status);
        end else begin
          es = exp_status.pop_front();
          check("status", status, es);
        end
      end
      prev_req  <= mem_req;
      prev_ack  <= mem_req && mem_ack;
      prev_busy <= status[51];
      prev_acc  <= {mem_we, mem_addr, mem_wdata};
    end
  end

  // Reference model: expected accesses and final status of one command.
  task automatic model_cmd(input logic [7:0] tag, input logic [3:0] op, input logic [19:0] addr,
                           input logic [15:0] len, input logic [15:0] data, input bit en,
                           output int unsigned issued);
    int unsigned n;
    logic [15:0] mism, rd, words, v;
    logic        to, bad;
    logic [19:0] a;
    mism  = '0;
    rd    = '0;
    words = '0;
    to    = 1'b0;
    bad   = (op > 4'd4);
    case (op)
      4'd1, 4'd2: n = 1;
      4'd3, 4'd4: n = 32'(len);
      default:    n = 0;
    endcase
    issued = n;
    if (n != 0 && !en) begin
      to     = 1'b1;
      n      = 0;
      issued = 1;
    end
    for (int unsigned i = 0; i < n; i++) begin
      a = addr + 20'(i);
      if (op == 4'd1 || op == 4'd3) begin
        ref_mem[a] = data;
        ref_wr[a]  = 1'b1;
        exp_acc.push_back('{we: 1'b1, addr: a, wdata: data});
      end else begin
        v  = ref_rd(a);
        rd = v;
        exp_acc.push_back('{we: 1'b0, addr: a, wdata: 16'h0000});
        if (op == 4'd4 && v != data && mism != 16'hFFFF) mism++;
      end
      words++;
    end
    exp_status.push_back({tag, op, 1'b0, bad, to, 1'b0, mism, rd, words});
    ref_last_tag = tag;
  endtask

  // Issue one command and wait (bounded) for it to finish.
  task automatic run_cmd(input logic [7:0] tag, input logic [3:0] op, input logic [19:0] addr,
                         input logic [15:0] len, input logic [15:0] data, input bit en,
                         input int unsigned dly, input bit inject);
    int unsigned issued, extra, rises, req_cyc;
    logic [7:0]  target;
    bit          last_req, done;
    ack_en    = en;
    ack_delay = dly;
    model_cmd(tag, op, addr, len, data, en, issued);
    target   = tag;
    rises    = 0;
    req_cyc  = 0;
    last_req = 1'b0;
    done     = 1'b0;
    @(posedge clk);
    #1;
    cmd = {tag, op, addr, len, data};
    for (int unsigned i = 0; i < WAIT_MAX && !done; i++) begin
      @(negedge clk);
      if (i == 0) check("req_before_accept", 64'(mem_req), 64'd0);
      if (i == 1) begin
        check("busy_after_accept", 64'(status[51]), 64'd1);
        check("req_latency", 64'(mem_req), 64'(issued != 0));
      end
      if (inject && i == 3) cmd = {8'h06, 4'd0, 52'd0};
      if (inject && i == 6) begin
        cmd = {8'h07, 4'd0, 52'd0};
        model_cmd(8'h07, 4'd0, 20'd0, 16'd0, 16'd0, en, extra);
        target = 8'h07;
      end
      if (mem_req && !last_req) rises++;
      if (mem_req) req_cyc++;
      last_req = mem_req;
      if (i > 0 && status[63:56] == target && !status[51]) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_wait actual=unfinished after %0d cycles required=done_tag %h", WAIT_MAX, target);
    end
    check("req_count", 64'(rises), 64'(issued));
    if (!en && issued != 0) check("timeout_req_cycles", 64'(req_cyc), 64'(TO));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=time limit reached required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_status", status, 64'd0);
    check("reset_mem_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
    #2 reset_ = 1'b1;
    repeat (5) @(negedge clk);
    check("tag0_after_reset_status", status, 64'd0);
    check("tag0_after_reset_req", 64'(mem_req), 64'd0);

    // Write then read back
    run_cmd(8'h01, 4'd1, 20'h00010, 16'd7, 16'hBEEF, 1'b1, 0, 1'b0);
    run_cmd(8'h02, 4'd2, 20'h00010, 16'd9, 16'h0000, 1'b1, 2, 1'b0);
    check("wr_rd_status", status, 64'h0220_0000_BEEF_0001);

    // Fill across the top of the address space
    run_cmd(8'h03, 4'd3, 20'hFFFFE, 16'd4, 16'h5A5A, 1'b1, 1, 1'b0);
    check("fill_wrap_status", status, 64'h0330_0000_0000_0004);

    // Check with one corrupted word
    run_cmd(8'h10, 4'd1, 20'h00000, 16'd0, 16'h0000, 1'b1, 0, 1'b0);
    run_cmd(8'h04, 4'd4, 20'hFFFFE, 16'd4, 16'h5A5A, 1'b1, 0, 1'b0);
    check("check_mismatch_status", status, 64'h0440_0001_5A5A_0004);

    // Timeout on a fill, with tag changes while busy
    run_cmd(8'h05, 4'd3, 20'h00200, 16'd3, 16'h1111, 1'b0, 0, 1'b1);
    check("ignore_while_busy_status", status, 64'h0700_0000_0000_0000);

    // Bad opcode
    run_cmd(8'h08, 4'd9, 20'h00300, 16'd2, 16'h2222, 1'b1, 0, 1'b0);
    check("bad_op_status", status, 64'h0894_0000_0000_0000);

    // Ack on the expiry cycle counts as an ack
    run_cmd(8'h09, 4'd1, 20'h00020, 16'd0, 16'h1357, 1'b1, 13, 1'b0);
    check("ack_at_expiry_status", status, 64'h0910_0000_0000_0001);
    run_cmd(8'h0A, 4'd3, 20'h00030, 16'd0, 16'h9999, 1'b1, 0, 1'b0);
    check("fill_len0_status", status, 64'h0A30_0000_0000_0000);
    run_cmd(8'h0B, 4'd4, 20'hFFFFF, 16'd2, 16'h5A5A, 1'b1, 13, 1'b0);

    // Randomized commands
    for (int k = 0; k < 60; k++) begin
      logic [7:0]  t;
      logic [3:0]  op;
      logic [19:0] a;
      logic [15:0] l, d;
      bit          en;
      int unsigned dly, r;
      do t = 8'($urandom); while (t == ref_last_tag);
      r = $urandom_range(0, 99);
      if (r < 8) op = 4'($urandom_range(5, 15));
      else if (r < 16) op = 4'd0;
      else op = 4'($urandom_range(1, 4));
      a   = ($urandom_range(0, 3) == 0) ? 20'hFFFFD + 20'($urandom_range(0, 2))
                                        : 20'($urandom_range(0, 63));
      l   = 16'($urandom_range(0, 5));
      d   = ($urandom_range(0, 1) == 0) ? 16'h5A5A : 16'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      dly = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 13) : $urandom_range(0, 3);
      run_cmd(t, op, a, l, d, en, dly, 1'b0);
    end

    // Reset in the middle of a request
    ack_en = 1'b0;
    @(posedge clk);
    #1 cmd = {8'h20, 4'd3, 20'h00100, 16'd5, 16'h1111};
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("reset_setup_req", 64'(seen), 64'd1);
    #2 reset_ = 1'b0;
    #1;
    check("midreset_req_drop", 64'(mem_req), 64'd0);
    check("midreset_status", status, 64'd0);
    check("midreset_mem_outputs", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
    cmd = {8'h00, 4'd1, 20'h00040, 16'd1, 16'hDEAD};
    ref_last_tag = 8'h00;
    repeat (2) @(negedge clk);
    #2 reset_ = 1'b1;
    ack_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req || status[51]) seen = 1'b1;
    end
    check("tag0_ignored", 64'(seen), 64'd0);
    check("tag0_status", status, 64'd0);
    run_cmd(8'h33, 4'd2, 20'h00010, 16'd0, 16'h0000, 1'b1, 1, 1'b0);

    repeat (4) @(negedge clk);
    check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
    check("status_queue_drained", 64'(exp_status.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peek_cmd_exec.md
PEEK_CMD_EXEC -- requirements
Module: peek_cmd_exec

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 1023, the number of cycles a memory request may wait for mem_ack before it is aborted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cmd, input, 64 bits: the command word written by the SPI peek slave, held stable between SPI transfers. Fields: [63:56] tag, [55:52] op, [51:32] addr, [31:16] len, [15:0] data.
REQ-005 The block SHALL have port status, output, 64 bits: the word returned to the SPI peek slave. Fields: [63:56] done_tag, [55:52] done_op, [51] busy, [50] bad_op, [49] timeout, [48] zero, [47:32] mismatch count, [31:16] last read data, [15:0] words completed.
REQ-006 The block SHALL have port mem_req, output, 1 bit: memory request valid.
REQ-007 The block SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port mem_addr, output, 20 bits: word address.
REQ-009 The block SHALL have port mem_wdata, output, 16 bits: write data.
REQ-010 The block SHALL have port mem_ack, input, 1 bit: one-cycle completion pulse for the current request.
REQ-011 The block SHALL have port mem_rdata, input, 16 bits: read data, valid in the mem_ack cycle of a read.

Function
REQ-012 New command: in IDLE, cmd.tag != last_tag SHALL accept cmd, latch all fields, set last_tag = cmd.tag, and set busy on the next cycle.
REQ-013 Tag changes while not IDLE SHALL be ignored; on return to IDLE, the current cmd is compared against last_tag.
REQ-014 Ops SHALL be: 0 NOP, 1 WRITE (one write of data to addr), 2 READ (one read of addr), 3 FILL (len writes of data from addr upward), 4 CHECK (len reads from addr upward, each compared to data).
REQ-015 Ops 5..15 SHALL complete with no memory access and bad_op = 1.
REQ-016 len SHALL be ignored for ops 0..2.
REQ-017 For FILL and CHECK, len = 0 SHALL complete with no memory access.
REQ-018 The FSM states SHALL be IDLE, ISSUE, NEXT and DONE.
REQ-019 IDLE -> ISSUE on acceptance when an access is needed; otherwise IDLE -> DONE.
REQ-020 ISSUE SHALL hold mem_req = 1 with stable mem_we, mem_addr and mem_wdata until mem_ack.
REQ-021 ISSUE -> NEXT on mem_ack, and ISSUE -> DONE with timeout = 1 after ACK_TIMEOUT cycles without mem_ack.
REQ-022 mem_req SHALL deassert in the cycle after mem_ack.
REQ-023 mem_req SHALL never be high in two consecutive transactions without an intervening low cycle.
REQ-024 NEXT SHALL increment the address modulo 2^20 (0xFFFFF wraps to 0x00000) and decrement the remaining count, then go to ISSUE if remaining > 0, else DONE.
REQ-025 NEXT SHALL last exactly 1 cycle.
REQ-026 DONE (1 cycle) SHALL write done_tag and done_op, clear busy, and return to IDLE.
REQ-027 On read ack, last read data SHALL be set to mem_rdata.
REQ-028 For CHECK, mem_rdata != data SHALL increment the mismatch count, saturating at 0xFFFF.
REQ-029 Each acked access SHALL increment words completed, modulo 2^16.
REQ-030 At command acceptance, bad_op, timeout, mismatch count, last read data and words completed SHALL clear to 0.
REQ-031 A timeout SHALL abort the remaining FILL/CHECK words; counts SHALL reflect only acked words.
REQ-032 mem_ack outside ISSUE SHALL be ignored.
REQ-033 mem_ack in the same cycle the timeout expires SHALL count as ack, with timeout = 0.
REQ-034 Latency SHALL be: acceptance to first mem_req = 1 cycle; last ack to busy = 0 = 2 cycles (NEXT, DONE).
REQ-035 Throughput SHALL be at most one access per 3 cycles with immediate ack.

Reset
REQ-036 reset_ low SHALL asynchronously force IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, status = 0 and last_tag = 0x00.
REQ-037 A reset mid-transaction SHALL drop mem_req immediately; the aborted command is not resumed.
REQ-038 After reset, a cmd with tag 0x00 SHALL NOT execute; the first command needs a nonzero tag.

Verification
REQ-039 Write/read: cmd tag 01 WRITE addr 0x00010 data 0xBEEF, then tag 02 READ addr 0x00010 with memory model echo -> status done_tag 02, done_op 2, last read data 0xBEEF, words completed 1, busy 0.
REQ-040 Fill wrap: tag 03 FILL addr 0xFFFFE len 4 data 0x5A5A -> writes at 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; words completed 4.
REQ-041 Check mismatch: memory holds 0x5A5A except one word 0x0000; tag 04 CHECK len 4 data 0x5A5A -> mismatch count 1, words completed 4.
REQ-042 Timeout: ACK_TIMEOUT = 15, mem_ack never asserted, tag 05 FILL len 3 -> mem_req high 15 cycles, then timeout 1, words completed 0, busy 0.
REQ-043 Busy/ignore: change tag to 06 NOP while 05 is running, then to 07 NOP -> only tag 07 executes after 05; bad op tag 08 op 9 -> bad_op 1, no mem_req.
REQ-044 Reset: reset_ low during ISSUE -> mem_req 0 in the same cycle, status 0; cmd tag 00 after reset -> no activity.
